// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter
// Shares one SDRAM controller command/response port between a frame-write
// requester and a frame-read requester, all in the sdram_clk domain.
// Whole bursts are granted; reads win by default, and a write that has waited
// STARVE_LIMIT cycles overrides them.
// Responses come back in order. A small owner-tag FIFO routes each response
// to the requester that issued the matching command.
// Optional statistics counters are enabled by defining SDRAM_ARB_STATS_EN.
module sdram_cmd_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 24,
    parameter int MAX_BURST    = 256,
    parameter int STARVE_LIMIT = 64,
    parameter int TAG_DEPTH    = 8
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_rst,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [DATA_WIDTH-1:0] wr_cmd_wdata,
    input  logic                  wr_cmd_last,
    output logic                  wr_resp_valid,
    input  logic                  wr_resp_ready,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic                  rd_cmd_last,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [DATA_WIDTH-1:0] rd_resp_rdata,
    output logic                  sdram_cmd_valid,
    input  logic                  sdram_cmd_ready,
    output logic                  sdram_cmd_rw,
    output logic [ADDR_WIDTH-1:0] sdram_cmd_addr,
    output logic [DATA_WIDTH-1:0] sdram_cmd_wdata,
    input  logic                  sdram_resp_valid,
    output logic                  sdram_resp_ready,
    input  logic [DATA_WIDTH-1:0] sdram_resp_rdata,
    output logic                  grant_rd,
    output logic                  grant_wr,
    output logic                  resp_err,
    output logic [31:0]           stat_rd_beats,
    output logic [31:0]           stat_wr_beats,
    output logic [31:0]           stat_wr_starve
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GNT_RD = 2'd1;
    localparam logic [1:0] ST_GNT_WR = 2'd2;

    localparam int TAG_AW   = $clog2(TAG_DEPTH);
    localparam int BEAT_W   = $clog2(MAX_BURST + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [1:0]           state_q, state_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [TAG_AW-1:0]    tag_wr_ptr_q, tag_wr_ptr_d;
    logic [TAG_AW-1:0]    tag_rd_ptr_q, tag_rd_ptr_d;
    logic [TAG_AW:0]      tag_cnt_q, tag_cnt_d;
    logic                 resp_err_q, resp_err_d;

    logic tag_full;
    logic tag_empty;
    logic head_is_wr;
    logic cmd_hs;
    logic cur_last;
    logic beat_at_limit;
    logic tag_push;
    logic tag_pop;
    logic starve_take;

    assign tag_full      = (tag_cnt_q == (TAG_AW + 1)'(TAG_DEPTH));
    assign tag_empty     = (tag_cnt_q == '0);
    assign head_is_wr    = tag_mem_q[tag_rd_ptr_q];
    assign beat_at_limit = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
    assign cmd_hs        = sdram_cmd_valid & sdram_cmd_ready;
    assign tag_push      = cmd_hs;
    assign tag_pop       = sdram_resp_valid & sdram_resp_ready & ~tag_empty;

    assign grant_rd      = (state_q == ST_GNT_RD);
    assign grant_wr      = (state_q == ST_GNT_WR);
    assign resp_err      = resp_err_q;
    assign rd_resp_rdata = sdram_resp_rdata;

    // Pass the granted requester's command straight through, held off while the tag FIFO is full
    always_comb begin
        sdram_cmd_valid = 1'b0;
        sdram_cmd_rw    = 1'b0;
        sdram_cmd_addr  = '0;
        sdram_cmd_wdata = '0;
        rd_cmd_ready    = 1'b0;
        wr_cmd_ready    = 1'b0;
        cur_last        = 1'b0;
        case (state_q)
            ST_GNT_RD: begin
                sdram_cmd_valid = rd_cmd_valid & ~tag_full;
                rd_cmd_ready    = sdram_cmd_ready & ~tag_full;
                sdram_cmd_addr  = rd_cmd_addr;
                cur_last        = rd_cmd_last;
            end
            ST_GNT_WR: begin
                sdram_cmd_valid = wr_cmd_valid & ~tag_full;
                wr_cmd_ready    = sdram_cmd_ready & ~tag_full;
                sdram_cmd_rw    = 1'b1;
                sdram_cmd_addr  = wr_cmd_addr;
                sdram_cmd_wdata = wr_cmd_wdata;
                cur_last        = wr_cmd_last;
            end
            default: ;
        endcase
    end

    // Arbitrate from IDLE, hold a grant for a whole burst and release on last or burst limit
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        starve_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_cmd_valid && (starve_q >= STARVE_W'(STARVE_LIMIT))) begin
                    state_d     = ST_GNT_WR;
                    starve_take = 1'b1;
                end else if (rd_cmd_valid) begin
                    state_d = ST_GNT_RD;
                end else if (wr_cmd_valid) begin
                    state_d = ST_GNT_WR;
                end
            end
            ST_GNT_RD, ST_GNT_WR: begin
                if (cmd_hs) begin
                    if (cur_last || beat_at_limit) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Count how long a write has been kept waiting; saturate, and clear when it gets the port
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_IDLE && state_d == ST_GNT_WR) begin
            starve_d = '0;
        end else if (wr_cmd_valid && state_q != ST_GNT_WR &&
                     starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Route each response by the owner tag at the FIFO head; drain strays when nothing is outstanding
    always_comb begin
        wr_resp_valid    = 1'b0;
        rd_resp_valid    = 1'b0;
        sdram_resp_ready = 1'b0;
        if (tag_empty) begin
            sdram_resp_ready = 1'b1;
        end else if (head_is_wr) begin
            wr_resp_valid    = sdram_resp_valid;
            sdram_resp_ready = wr_resp_ready;
        end else begin
            rd_resp_valid    = sdram_resp_valid;
            sdram_resp_ready = rd_resp_ready;
        end
    end

    // Owner-tag FIFO bookkeeping plus the sticky stray-response flag
    always_comb begin
        tag_mem_d    = tag_mem_q;
        tag_wr_ptr_d = tag_wr_ptr_q;
        tag_rd_ptr_d = tag_rd_ptr_q;
        tag_cnt_d    = tag_cnt_q;
        if (tag_push) begin
            tag_mem_d[tag_wr_ptr_q] = (state_q == ST_GNT_WR);
            tag_wr_ptr_d            = tag_wr_ptr_q + 1'b1;
        end
        if (tag_pop) begin
            tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
        end
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase
        resp_err_d = resp_err_q | (sdram_resp_valid & tag_empty);
    end

    // Register all arbiter state
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            starve_q     <= '0;
            tag_mem_q    <= '0;
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            starve_q     <= starve_d;
            tag_mem_q    <= tag_mem_d;
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
            tag_cnt_q    <= tag_cnt_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [31:0] stat_rd_beats_q, stat_rd_beats_d;
    logic [31:0] stat_wr_beats_q, stat_wr_beats_d;
    logic [31:0] stat_wr_starve_q, stat_wr_starve_d;

    // Count issued beats per owner and starvation overrides, wrapping freely
    always_comb begin
        stat_rd_beats_d  = stat_rd_beats_q;
        stat_wr_beats_d  = stat_wr_beats_q;
        stat_wr_starve_d = stat_wr_starve_q;
        if (cmd_hs && state_q == ST_GNT_RD) stat_rd_beats_d = stat_rd_beats_q + 32'd1;
        if (cmd_hs && state_q == ST_GNT_WR) stat_wr_beats_d = stat_wr_beats_q + 32'd1;
        if (starve_take) stat_wr_starve_d = stat_wr_starve_q + 32'd1;
    end

    // Register the statistics counters
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            stat_rd_beats_q  <= '0;
            stat_wr_beats_q  <= '0;
            stat_wr_starve_q <= '0;
        end else begin
            stat_rd_beats_q  <= stat_rd_beats_d;
            stat_wr_beats_q  <= stat_wr_beats_d;
            stat_wr_starve_q <= stat_wr_starve_d;
        end
    end

    assign stat_rd_beats  = stat_rd_beats_q;
    assign stat_wr_beats  = stat_wr_beats_q;
    assign stat_wr_starve = stat_wr_starve_q;
`else
    logic unused_starve_take;
    assign unused_starve_take = starve_take;
    assign stat_rd_beats  = '0;
    assign stat_wr_beats  = '0;
    assign stat_wr_starve = '0;
`endif

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter
// Directed bench for sdram_cmd_arbiter with MAX_BURST=8, STARVE_LIMIT=16, TAG_DEPTH=8.
// A small in-order controller model answers each command, and read data equals the
// low 16 address bits. Statistics expectations follow SDRAM_ARB_STATS_EN.
module tb_sdram_cmd_arbiter;

    logic        sdram_clk;
    logic        sdram_rst;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready;
    logic [23:0] wr_cmd_addr;
    logic [15:0] wr_cmd_wdata;
    logic        wr_cmd_last;
    logic        wr_resp_valid;
    logic        wr_resp_ready;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [23:0] rd_cmd_addr;
    logic        rd_cmd_last;
    logic        rd_resp_valid;
    logic        rd_resp_ready;
    logic [15:0] rd_resp_rdata;
    logic        sdram_cmd_valid;
    logic        sdram_cmd_ready;
    logic        sdram_cmd_rw;
    logic [23:0] sdram_cmd_addr;
    logic [15:0] sdram_cmd_wdata;
    logic        sdram_resp_valid;
    logic        sdram_resp_ready;
    logic [15:0] sdram_resp_rdata;
    logic        grant_rd;
    logic        grant_wr;
    logic        resp_err;
    logic [31:0] stat_rd_beats;
    logic [31:0] stat_wr_beats;
    logic [31:0] stat_wr_starve;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        hs_rw[$];
    logic        hs_grd[$];
    int          hs_cyc[$];
    logic [15:0] rd_data[$];
    int          wr_acks;
    bit          saw_gwr;

    logic        mq_rw[$];
    logic [15:0] mq_data[$];
    bit          resp_en;
    bit          inject;
    int          budget;

    sdram_cmd_arbiter #(
        .DATA_WIDTH(16), .ADDR_WIDTH(24), .MAX_BURST(8), .STARVE_LIMIT(16), .TAG_DEPTH(8)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_wdata(wr_cmd_wdata), .wr_cmd_last(wr_cmd_last),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_last(rd_cmd_last),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_rdata(rd_resp_rdata),
        .sdram_cmd_valid(sdram_cmd_valid), .sdram_cmd_ready(sdram_cmd_ready),
        .sdram_cmd_rw(sdram_cmd_rw), .sdram_cmd_addr(sdram_cmd_addr), .sdram_cmd_wdata(sdram_cmd_wdata),
        .sdram_resp_valid(sdram_resp_valid), .sdram_resp_ready(sdram_resp_ready),
        .sdram_resp_rdata(sdram_resp_rdata),
        .grant_rd(grant_rd), .grant_wr(grant_wr), .resp_err(resp_err),
        .stat_rd_beats(stat_rd_beats), .stat_wr_beats(stat_wr_beats), .stat_wr_starve(stat_wr_starve)
    );

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    function automatic int stat_exp(input int n);
`ifdef SDRAM_ARB_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Observe handshakes and responses half a cycle before the edge that takes them
    always @(negedge sdram_clk) begin
        cyc++;
        if (sdram_rst) begin
            mq_rw.delete();
            mq_data.delete();
        end else begin
            if (sdram_cmd_valid && sdram_cmd_ready) begin
                mq_rw.push_back(sdram_cmd_rw);
                mq_data.push_back(sdram_cmd_rw ? 16'hBEEF : sdram_cmd_addr[15:0]);
                hs_rw.push_back(sdram_cmd_rw);
                hs_grd.push_back(grant_rd);
                hs_cyc.push_back(cyc);
            end
            if (sdram_resp_valid && sdram_resp_ready && mq_rw.size() > 0) begin
                mq_rw.pop_front();
                mq_data.pop_front();
                if (!resp_en && budget > 0) budget--;
            end
            if (rd_resp_valid && rd_resp_ready) rd_data.push_back(rd_resp_rdata);
            if (wr_resp_valid && wr_resp_ready) wr_acks++;
            if (grant_wr) saw_gwr = 1'b1;
        end
    end

    // In-order controller model presenting the head response just after each edge
    always @(posedge sdram_clk) begin
        #1;
        if (mq_rw.size() > 0) begin
            sdram_resp_valid = resp_en || (budget > 0);
            sdram_resp_rdata = mq_data[0];
        end else begin
            sdram_resp_valid = 1'b0;
            sdram_resp_rdata = 16'h0000;
        end
        if (inject) sdram_resp_valid = 1'b1;
    end

    task automatic tick();
        @(posedge sdram_clk);
        #2;
    endtask

    task automatic clear_logs();
        hs_rw.delete();
        hs_grd.delete();
        hs_cyc.delete();
        rd_data.delete();
        wr_acks = 0;
        saw_gwr = 1'b0;
    endtask

    task automatic do_reset();
        rd_cmd_valid = 1'b0; rd_cmd_addr = '0; rd_cmd_last = 1'b0;
        wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_wdata = '0; wr_cmd_last = 1'b0;
        rd_resp_ready = 1'b1; wr_resp_ready = 1'b1; sdram_cmd_ready = 1'b1;
        resp_en = 1'b1; budget = 0; inject = 1'b0;
        sdram_rst = 1'b1;
        repeat (2) tick();
        sdram_rst = 1'b0;
        clear_logs();
        tick();
    endtask

    task automatic rd_burst(input logic [23:0] a, input int n, input bit with_last);
        int w;
        for (int i = 0; i < n; i++) begin
            rd_cmd_valid = 1'b1;
            rd_cmd_addr  = a + 24'(i);
            rd_cmd_last  = with_last && (i == n - 1);
            w = 0;
            while (!rd_cmd_ready) begin
                tick();
                w++;
                if (w > 300) begin
                    checks++; errors++;
                    $display("[TB] FAIL rd_burst_timeout: beat %0d of addr %h not accepted, waited %0d cycles, required <= 300", i, a, w);
                    rd_cmd_valid = 1'b0; rd_cmd_last = 1'b0;
                    return;
                end
            end
            tick();
        end
        rd_cmd_valid = 1'b0;
        rd_cmd_last  = 1'b0;
    endtask

    task automatic wr_burst(input logic [23:0] a, input int n, input bit with_last);
        int w;
        for (int i = 0; i < n; i++) begin
            wr_cmd_valid = 1'b1;
            wr_cmd_addr  = a + 24'(i);
            wr_cmd_wdata = 16'hA000 + 16'(i);
            wr_cmd_last  = with_last && (i == n - 1);
            w = 0;
            while (!wr_cmd_ready) begin
                tick();
                w++;
                if (w > 300) begin
                    checks++; errors++;
                    $display("[TB] FAIL wr_burst_timeout: beat %0d of addr %h not accepted, waited %0d cycles, required <= 300", i, a, w);
                    wr_cmd_valid = 1'b0; wr_cmd_last = 1'b0;
                    return;
                end
            end
            tick();
        end
        wr_cmd_valid = 1'b0;
        wr_cmd_last  = 1'b0;
    endtask

    // Outputs during reset with both requesters pushing must all sit at zero
    task automatic test_reset();
        sdram_rst = 1'b1;
        rd_cmd_valid = 1'b1; rd_cmd_addr = 24'h123456; rd_cmd_last = 1'b0;
        wr_cmd_valid = 1'b1; wr_cmd_addr = 24'hABCDEF; wr_cmd_wdata = 16'h1234; wr_cmd_last = 1'b0;
        sdram_cmd_ready = 1'b1; rd_resp_ready = 1'b1; wr_resp_ready = 1'b1;
        resp_en = 1'b1; budget = 0; inject = 1'b0;
        repeat (3) tick();
        checks++; if (grant_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_rd: got %b expected 0", grant_rd); end
        checks++; if (grant_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_wr: got %b expected 0", grant_wr); end
        checks++; if (rd_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_ready: got %b expected 0", rd_cmd_ready); end
        checks++; if (wr_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_ready: got %b expected 0", wr_cmd_ready); end
        checks++; if (sdram_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", sdram_cmd_valid); end
        checks++; if (sdram_cmd_rw !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_rw: got %b expected 0", sdram_cmd_rw); end
        checks++; if (sdram_cmd_addr !== 24'h0) begin errors++; $display("[TB] FAIL reset_cmd_addr: got %h expected 000000", sdram_cmd_addr); end
        checks++; if (sdram_cmd_wdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_cmd_wdata: got %h expected 0000", sdram_cmd_wdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (stat_rd_beats !== 32'd0) begin errors++; $display("[TB] FAIL reset_stat_rd: got %0d expected 0", stat_rd_beats); end
        checks++; if (stat_wr_beats !== 32'd0) begin errors++; $display("[TB] FAIL reset_stat_wr: got %0d expected 0", stat_wr_beats); end
        checks++; if (stat_wr_starve !== 32'd0) begin errors++; $display("[TB] FAIL reset_stat_starve: got %0d expected 0", stat_wr_starve); end
        rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0;
        sdram_rst = 1'b0;
        tick();
        checks++; if (grant_rd !== 1'b0 || grant_wr !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_request_grant: got rd=%b wr=%b expected 0 0", grant_rd, grant_wr); end
    endtask

    // Single 8-beat read with everything ready
    task automatic test_read_burst();
        do_reset();
        rd_burst(24'h000000, 8, 1'b1);
        repeat (12) tick();
        checks++; if (hs_rw.size() != 8) begin errors++; $display("[TB] FAIL rd8_beats: got %0d expected 8", hs_rw.size()); end
        for (int i = 0; i < hs_rw.size(); i++) begin
            checks++; if (hs_rw[i] !== 1'b0 || hs_grd[i] !== 1'b1) begin errors++; $display("[TB] FAIL rd8_owner_%0d: got rw=%b grant_rd=%b expected 0 1", i, hs_rw[i], hs_grd[i]); end
        end
        if (hs_cyc.size() == 8) begin
            checks++; if (hs_cyc[7] - hs_cyc[0] != 7) begin errors++; $display("[TB] FAIL rd8_back_to_back: got span %0d expected 7", hs_cyc[7] - hs_cyc[0]); end
        end
        checks++; if (rd_data.size() != 8) begin errors++; $display("[TB] FAIL rd8_resp_count: got %0d expected 8", rd_data.size()); end
        for (int i = 0; i < rd_data.size(); i++) begin
            checks++; if (rd_data[i] !== 16'(i)) begin errors++; $display("[TB] FAIL rd8_rdata_%0d: got %h expected %h", i, rd_data[i], 16'(i)); end
        end
        checks++; if (saw_gwr !== 1'b0) begin errors++; $display("[TB] FAIL rd8_grant_wr_seen: got %b expected 0", saw_gwr); end
        checks++; if (stat_rd_beats !== 32'(stat_exp(8))) begin errors++; $display("[TB] FAIL rd8_stat_rd: got %0d expected %0d", stat_rd_beats, stat_exp(8)); end
    endtask

    // Simultaneous 4-beat requests: read first, one bubble, then write
    task automatic test_simultaneous();
        logic [7:0] seq;
        do_reset();
        fork
            rd_burst(24'h000100, 4, 1'b1);
            wr_burst(24'h000200, 4, 1'b1);
        join
        repeat (12) tick();
        seq = '0;
        checks++; if (hs_rw.size() != 8) begin errors++; $display("[TB] FAIL sim_beats: got %0d expected 8", hs_rw.size()); end
        else begin
            for (int i = 0; i < 8; i++) seq[i] = hs_rw[i];
            checks++; if (seq !== 8'hF0) begin errors++; $display("[TB] FAIL sim_rw_seq: got %b expected 11110000 (beat0 at lsb)", seq); end
            checks++; if (hs_cyc[4] - hs_cyc[3] != 2) begin errors++; $display("[TB] FAIL sim_bubble: got gap %0d expected 2", hs_cyc[4] - hs_cyc[3]); end
        end
        checks++; if (wr_acks != 4) begin errors++; $display("[TB] FAIL sim_wr_acks: got %0d expected 4", wr_acks); end
        checks++; if (rd_data.size() != 4) begin errors++; $display("[TB] FAIL sim_rd_count: got %0d expected 4", rd_data.size()); end
        for (int i = 0; i < rd_data.size(); i++) begin
            checks++; if (rd_data[i] !== 16'h0100 + 16'(i)) begin errors++; $display("[TB] FAIL sim_rdata_%0d: got %h expected %h", i, rd_data[i], 16'h0100 + 16'(i)); end
        end
        checks++; if (stat_wr_starve !== 32'd0) begin errors++; $display("[TB] FAIL sim_stat_starve: got %0d expected 0", stat_wr_starve); end
    endtask

    // Back-to-back reads: a write waiting since the start wins after 16 read beats
    task automatic test_starvation();
        int first_wr;
        do_reset();
        fork
            begin
                for (int b = 0; b < 6; b++) rd_burst(24'h001000 + 24'(b * 4), 4, 1'b1);
            end
            wr_burst(24'h002000, 4, 1'b1);
        join
        repeat (12) tick();
        first_wr = -1;
        for (int i = hs_rw.size() - 1; i >= 0; i--) if (hs_rw[i] === 1'b1) first_wr = i;
        checks++; if (first_wr != 16) begin errors++; $display("[TB] FAIL starve_first_write_index: got %0d expected 16", first_wr); end
        if (first_wr >= 1) begin
            checks++; if (hs_cyc[first_wr] - hs_cyc[first_wr - 1] != 2) begin errors++; $display("[TB] FAIL starve_bubble: got gap %0d expected 2", hs_cyc[first_wr] - hs_cyc[first_wr - 1]); end
        end
        checks++; if (hs_rw.size() != 28) begin errors++; $display("[TB] FAIL starve_total_beats: got %0d expected 28", hs_rw.size()); end
        checks++; if (stat_wr_starve !== 32'(stat_exp(1))) begin errors++; $display("[TB] FAIL starve_stat: got %0d expected %0d", stat_wr_starve, stat_exp(1)); end
        checks++; if (stat_rd_beats !== 32'(stat_exp(24))) begin errors++; $display("[TB] FAIL starve_stat_rd: got %0d expected %0d", stat_rd_beats, stat_exp(24)); end
    endtask

    // Write without last: forced release after 8 beats, grant held when valid drops mid-burst
    task automatic test_max_burst();
        do_reset();
        wr_burst(24'h004000, 10, 1'b0);
        checks++; if (hs_cyc.size() != 10) begin errors++; $display("[TB] FAIL maxb_beats: got %0d expected 10", hs_cyc.size()); end
        else begin
            checks++; if (hs_cyc[7] - hs_cyc[0] != 7) begin errors++; $display("[TB] FAIL maxb_first_grant_span: got %0d expected 7", hs_cyc[7] - hs_cyc[0]); end
            checks++; if (hs_cyc[8] - hs_cyc[7] != 2) begin errors++; $display("[TB] FAIL maxb_regrant_gap: got %0d expected 2", hs_cyc[8] - hs_cyc[7]); end
        end
        rd_cmd_valid = 1'b1; rd_cmd_addr = 24'h000777;
        repeat (5) tick();
        checks++; if (grant_wr !== 1'b1) begin errors++; $display("[TB] FAIL maxb_hold_grant_wr: got %b expected 1", grant_wr); end
        checks++; if (rd_cmd_ready !== 1'b0 || grant_rd !== 1'b0) begin errors++; $display("[TB] FAIL maxb_hold_blocks_rd: got ready=%b grant_rd=%b expected 0 0", rd_cmd_ready, grant_rd); end
        rd_cmd_valid = 1'b0;
        wr_burst(24'h00400A, 1, 1'b1);
        tick();
        checks++; if (grant_wr !== 1'b0) begin errors++; $display("[TB] FAIL maxb_release_on_last: got %b expected 0", grant_wr); end
        repeat (12) tick();
        checks++; if (wr_acks != 11) begin errors++; $display("[TB] FAIL maxb_wr_acks: got %0d expected 11", wr_acks); end
        checks++; if (stat_wr_beats !== 32'(stat_exp(11))) begin errors++; $display("[TB] FAIL maxb_stat_wr: got %0d expected %0d", stat_wr_beats, stat_exp(11)); end
    endtask

    // Responses held back: only 8 beats may be outstanding, 3 responses free 3 beats
    task automatic test_tag_full();
        do_reset();
        resp_en = 1'b0;
        fork
            rd_burst(24'h000500, 12, 1'b1);
            begin
                repeat (20) tick();
                checks++; if (hs_rw.size() != 8) begin errors++; $display("[TB] FAIL full_issued: got %0d expected 8", hs_rw.size()); end
                checks++; if (rd_cmd_ready !== 1'b0 || sdram_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_blocked: got ready=%b valid=%b expected 0 0", rd_cmd_ready, sdram_cmd_valid); end
                checks++; if (grant_rd !== 1'b1) begin errors++; $display("[TB] FAIL full_grant_held: got %b expected 1", grant_rd); end
                budget = 3;
                repeat (10) tick();
                checks++; if (hs_rw.size() != 11) begin errors++; $display("[TB] FAIL full_after_release: got %0d expected 11", hs_rw.size()); end
                checks++; if (rd_data.size() != 3) begin errors++; $display("[TB] FAIL full_resp_count: got %0d expected 3", rd_data.size()); end
                for (int i = 0; i < rd_data.size(); i++) begin
                    checks++; if (rd_data[i] !== 16'h0500 + 16'(i)) begin errors++; $display("[TB] FAIL full_rdata_%0d: got %h expected %h", i, rd_data[i], 16'h0500 + 16'(i)); end
                end
                checks++; if (rd_cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_blocked_again: got %b expected 0", rd_cmd_ready); end
                resp_en = 1'b1;
            end
        join
        repeat (15) tick();
        checks++; if (rd_data.size() != 12) begin errors++; $display("[TB] FAIL full_all_resp: got %0d expected 12", rd_data.size()); end
    endtask

    // Stray response with nothing outstanding: drained, resp_err sticks until reset
    task automatic test_resp_err();
        do_reset();
        inject = 1'b1;
        tick();
        checks++; if (sdram_resp_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_drain_ready: got %b expected 1", sdram_resp_ready); end
        checks++; if (rd_resp_valid !== 1'b0 || wr_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL err_not_routed: got rd=%b wr=%b expected 0 0", rd_resp_valid, wr_resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL err_before_edge: got %b expected 0", resp_err); end
        inject = 1'b0;
        tick();
        checks++; if (resp_err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b expected 1", resp_err); end
        rd_burst(24'h000600, 2, 1'b1);
        repeat (8) tick();
        checks++; if (resp_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected 1", resp_err); end
        checks++; if (rd_data.size() != 2) begin errors++; $display("[TB] FAIL err_later_reads: got %0d expected 2", rd_data.size()); end
        do_reset();
        checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared_by_reset: got %b expected 0", resp_err); end
    endtask

    initial begin
        sdram_resp_valid = 1'b0;
        sdram_resp_rdata = 16'h0000;
        wr_acks = 0;
        saw_gwr = 1'b0;
        test_reset();
        test_read_burst();
        test_simultaneous();
        test_starvation();
        test_max_burst();
        test_tag_full();
        test_resp_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
